wb_daq_sram_slave: RTL and testbench
====================================

// Module: wb_daq_sram_slave
// PURPOSE
//  Wishbone B3 responder: on-chip sample SRAM. Target of the DAQ bus master's
//  sample writes; also read back by the CPU over the same bus. Supports classic
//  cycles and registered-feedback incrementing bursts (linear/wrap-4/8/16).
//  Sits on the system bus opposite the DAQ bus master.
// PARAMETERS
//  dw          32   data width (fixed 4 byte lanes)
//  aw          32   Wishbone byte-address width
//  depth_log2  10   log2 of memory depth in dw-bit words (1024 words)
// PORTS
//  wb_clk    in   1          bus clock; all logic on rising edge
//  wb_rst    in   1          reset, asynchronous, active-high
//  wb_adr_i  in   aw         byte address; word index = adr[depth_log2+1:2]
//  wb_dat_i  in   dw         write data
//  wb_sel_i  in   4          byte-lane enables (bit n -> dat[8n+7:8n])
//  wb_we_i   in   1          1 = write
//  wb_cyc_i  in   1          cycle valid
//  wb_stb_i  in   1          strobe
//  wb_cti_i  in   3          000 classic, 010 incr burst, 111 end-of-burst
//  wb_bte_i  in   2          00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wb_dat_o  out  dw         read data, valid while wb_ack_o=1 and we=0
//  wb_ack_o  out  1          beat acknowledge
//  wb_err_o  out  1          out-of-range access error
//  wb_rty_o  out  1          constant 0
// BEHAVIOUR
//  - Reset: state IDLE, ack_r=0, err_r=0, wb_dat_o=0, addr counter=0; RAM not cleared.
//  - wb_ack_o = ack_r & wb_cyc_i & wb_stb_i; wb_err_o = err_r & wb_cyc_i & wb_stb_i.
//    A beat completes only on an edge where wb_ack_o=1.
//  - Range: out-of-range iff adr[aw-1:depth_log2+2] != 0.
//  - FSM IDLE:
//    cyc&stb&!ack_r&!err_r in range: latch word addr; read RAM -> wb_dat_o;
//      ack_r<=1 (1-cycle latency). cti==010 -> BURST, else -> CLASSIC.
//    Out of range: err_r<=1 for one cycle, no write, stay IDLE, no burst.
//  - CLASSIC: at ack edge: write selected lanes if we; ack_r<=0; -> IDLE.
//    Min 2 cycles/access; no back-to-back acks.
//  - BURST, at each completed beat:
//    write selected lanes if we, at current addr;
//    cti==111 -> ack_r<=0, -> IDLE;
//    else addr <= next(addr,bte), prefetch RAM[next] -> wb_dat_o, ack_r stays 1
//      (1 beat/cycle).
//  - next(): linear = addr+1 mod 2^depth_log2 (wraps at memory end);
//    wrapN = low log2(N) bits increment modulo N, upper bits held.
//  - Master wait state in BURST (cyc=1, stb=0): hold addr and dat_o, no write;
//    resume on stb.
//  - cyc=0 in any state: ack_r<=0, err_r<=0, -> IDLE next edge; a beat without
//    ack is not written.
//  - Reset mid-burst: immediate return to reset values; partial burst words
//    already written persist.
//  - wb_sel_i=0000 write: acked, RAM unchanged.
// STRUCTURE
//  - Shared include wb_daq_defines.vh: CTI_CLASSIC/CTI_INCR/CTI_EOB and
//    BTE_LINEAR/WRAP4/WRAP8/WRAP16 constants, also used by wb_daq_bus_master.
//  - Sub-module wb_daq_ram: single-port sync RAM, per-byte write enable,
//    registered read; FSM, address counter and wrap logic stay in this module.
// TESTING
//  1 Classic write 0xDEADBEEF @0x10 sel=1111, then classic read @0x10
//    -> ack 1 cycle after stb each, data 0xDEADBEEF, ack low after each.
//  2 Byte lanes: write 0x11223344 @0x20 then sel=0010 write 0x0000AA00
//    -> readback 0x1122AA44.
//  3 Linear write burst of 4 @0x0 (cti 010,010,010,111), data 1..4
//    -> 4 consecutive acks; read burst returns 1,2,3,4 at one beat/cycle.
//  4 Wrap-4 read burst starting @0x08 (word 2) -> words 2,3,0,1 returned;
//    linear burst from last word (0xFFC) wraps to word 0.
//  5 Access @0x1000 (depth 1024) -> wb_err_o one cycle, no ack, RAM unchanged;
//    wb_rty_o always 0.
//  6 Mid-burst stb low 2 cycles, then resume; separately cyc drop and wb_rst
//    mid-burst -> held addr resumes correctly; drop/reset gives IDLE, ack=0,
//    no spurious write.

Source files
------------

// File: rtl/wb_daq_sram_slave_pkg.sv
// ----------------------------------------------------------------------------
// wb_daq_sram_slave_pkg
// Shared Wishbone burst encodings and slave FSM state type for the DAQ sample
// SRAM. The CTI/BTE constants are also used by the DAQ bus master side.
// ----------------------------------------------------------------------------
package wb_daq_sram_slave_pkg;

    // Cycle type identifiers (wb_cti_i)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extensions (wb_bte_i)
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST
    } state_t;

    // Mask of the word-address bits that cycle inside a wrapping burst.
    // Zero means a linear burst (the whole address increments).
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        logic [3:0] m;
        case (bte)
            BTE_LINEAR: m = 4'h0;
            BTE_WRAP4:  m = 4'h3;
            BTE_WRAP8:  m = 4'h7;
            BTE_WRAP16: m = 4'hF;
            default:    m = 4'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_daq_sram_slave_ram.sv
// ----------------------------------------------------------------------------
// wb_daq_sram_slave_ram
// Single-port synchronous sample RAM with per-byte write enables and a
// registered read port. The read register is the bus read-data register, so
// it is reset and only updated when a read is requested (holds otherwise).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (read register only)
//   we, sel         write strobe and byte-lane enables
//   re              read strobe: load rdata from mem[addr]
//   addr            word address
//   wdata, rdata    write data in, registered read data out
// ----------------------------------------------------------------------------
module wb_daq_sram_slave_ram #(
    parameter int dw         = 32,
    parameter int depth_log2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [dw/8-1:0]       sel,
    input  logic [depth_log2-1:0] addr,
    input  logic [dw-1:0]         wdata,
    output logic [dw-1:0]         rdata
);

    logic [dw-1:0] mem [2**depth_log2];

    // NOTE: the storage array has no reset so it maps onto a RAM macro; sample
    // contents simply survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < dw/8; i++) begin
                if (sel[i]) begin
                    // NOTE: non-blocking assignments for all clocked state so
                    // every register samples pre-edge values.
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_daq_sram_slave.sv
// ----------------------------------------------------------------------------
// wb_daq_sram_slave
// Wishbone B3 responder in front of the on-chip sample SRAM. Written by the
// DAQ bus master, read back by the CPU. Handles classic cycles (ack one cycle
// after strobe, no back-to-back acks) and registered-feedback incrementing
// bursts (linear, wrap-4/8/16) at one beat per cycle.
// Ports:
//   wb_clk, wb_rst  bus clock, asynchronous active-high reset
//   wb_adr_i        byte address (word index = adr[depth_log2+1:2])
//   wb_dat_i/o      write data in / read data out
//   wb_sel_i        byte-lane enables
//   wb_we_i         write enable
//   wb_cyc_i/stb_i  cycle and strobe
//   wb_cti_i/bte_i  cycle type and burst type
//   wb_ack_o        beat acknowledge
//   wb_err_o        out-of-range access
//   wb_rty_o        retry, never used
// ----------------------------------------------------------------------------
module wb_daq_sram_slave
    import wb_daq_sram_slave_pkg::*;
#(
    parameter int dw         = 32,
    parameter int aw         = 32,
    parameter int depth_log2 = 10
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    state_t                state;
    logic                  ack_r;
    logic                  err_r;
    logic [depth_log2-1:0] addr;
    logic [depth_log2-1:0] next_addr;
    logic [depth_log2-1:0] adr_word;
    logic [depth_log2-1:0] mask;
    logic                  req;
    logic                  beat;
    logic                  in_range;
    logic                  ram_we;
    logic                  ram_re;
    logic [depth_log2-1:0] ram_addr;
    logic                  unused_adr_bits;

    assign req      = wb_cyc_i & wb_stb_i;
    assign beat     = ack_r & req;           // a beat completes on this edge
    assign wb_ack_o = beat;
    assign wb_err_o = err_r & req;
    assign wb_rty_o = 1'b0;

    assign adr_word        = wb_adr_i[depth_log2+1:2];
    assign in_range        = (wb_adr_i[aw-1:depth_log2+2] == '0);
    assign unused_adr_bits = ^wb_adr_i[1:0];

    // Burst address step: wrapping bursts only advance the low bits selected
    // by the mask; linear bursts roll over at the end of the memory.
    always_comb begin
        mask = depth_log2'(wrap_mask(wb_bte_i));
        if (mask == '0) begin
            next_addr = addr + 1'b1;
        end else begin
            next_addr = (addr & ~mask) | ((addr + 1'b1) & mask);
        end
    end

    // RAM port steering. The read on request acceptance and the burst
    // prefetch land in the read register by the next edge, so data is ready
    // exactly when ack is shown.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr;
        case (state)
            ST_IDLE: begin
                if (req && !ack_r && !err_r && in_range) begin
                    ram_re   = 1'b1;
                    ram_addr = adr_word;
                end
            end
            ST_CLASSIC: begin
                if (beat && wb_we_i) begin
                    ram_we = 1'b1;
                end
            end
            ST_BURST: begin
                if (beat) begin
                    if (wb_we_i) begin
                        ram_we = 1'b1;
                    end else if (wb_cti_i != CTI_EOB) begin
                        ram_re   = 1'b1;
                        ram_addr = next_addr;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state <= ST_IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            addr  <= '0;
        end else if (!wb_cyc_i) begin
            // Master abandoned the cycle: drop everything, nothing is written.
            state <= ST_IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    err_r <= 1'b0;
                    // err_r gate keeps the error pulse to a single cycle
                    if (wb_stb_i && !ack_r && !err_r) begin
                        if (in_range) begin
                            addr  <= adr_word;
                            ack_r <= 1'b1;
                            state <= (wb_cti_i == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_CLASSIC: begin
                    if (beat) begin
                        ack_r <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    // stb low is a master wait state: addr and read data hold
                    if (beat) begin
                        if (wb_cti_i == CTI_EOB) begin
                            ack_r <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            addr <= next_addr;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_daq_sram_slave_ram #(
        .dw         (dw),
        .depth_log2 (depth_log2)
    ) u_ram (
        .clk   (wb_clk),
        .rst   (wb_rst),
        .we    (ram_we),
        .re    (ram_re),
        .sel   (wb_sel_i),
        .addr  (ram_addr),
        .wdata (wb_dat_i),
        .rdata (wb_dat_o)
    );

endmodule

// File: tb/tb_wb_daq_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_wb_daq_sram_slave
// Scoreboard bench for the DAQ sample SRAM slave. The master tasks drive
// classic, burst and out-of-range cycles, keep a word-array model of memory
// and queue expected read data; an independent monitor pops the queue on
// every read acknowledge and compares against wb_dat_o.
// ----------------------------------------------------------------------------
module tb_wb_daq_sram_slave;
    import wb_daq_sram_slave_pkg::*;

    localparam int DEPTH = 1024;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    always #5 wb_clk = ~wb_clk;

    wb_daq_sram_slave dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Word visited by beat i of a burst starting at word 'start'.
    function automatic int burst_word(input int start, input int i, input logic [1:0] bte);
        int n;
        int base;
        case (bte)
            BTE_WRAP4:  n = 4;
            BTE_WRAP8:  n = 8;
            BTE_WRAP16: n = 16;
            default:    n = 0;
        endcase
        if (n == 0) return (start + i) % DEPTH;
        base = start - (start % n);
        return base + ((start % n) + i) % n;
    endfunction

    // Scoreboard monitor: every read acknowledge consumes one expectation.
    always @(negedge wb_clk) begin
        if (wb_ack_o === 1'b1 && wb_we_i === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read_ack_unexpected: got data 0x%08h, wanted no ack at t=%0t",
                         wb_dat_o, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", wb_dat_o, mon_exp);
            end
        end
        if (wb_rty_o !== 1'b0) check("rty_low", {31'd0, wb_rty_o}, 32'd0);
    end

    // Returns the number of negedges without ack before ack was seen.
    task automatic wait_ack(output int waits);
        waits = 0;
        @(negedge wb_clk);
        while (wb_ack_o !== 1'b1 && waits <= 32) begin
            waits++;
            @(negedge wb_clk);
        end
        if (wb_ack_o !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no ack, wanted ack within 32 cycles at t=%0t", $time);
        end
    endtask

    task automatic classic(input logic [31:0] a, input bit we, input logic [31:0] d,
                           input logic [3:0] sel);
        int waits;
        int w;
        w = int'(a[11:2]);
        @(posedge wb_clk); #1;
        wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel;
        wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        if (!we) exp_q.push_back(model[w]);
        wait_ack(waits);
        check("classic_latency", waits, 1);
        if (we) model[w] = merge(model[w], d, sel);
        // strobe still held: the slave must not ack again right away
        @(negedge wb_clk);
        check("classic_ack_drop", {31'd0, wb_ack_o}, 32'd0);
        @(posedge wb_clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic oor(input logic [31:0] a, input bit we);
        @(posedge wb_clk); #1;
        wb_adr_i = a; wb_we_i = we; wb_dat_i = $urandom; wb_sel_i = 4'hF;
        wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge wb_clk);
        @(negedge wb_clk);
        check("oor_err", {31'd0, wb_err_o}, 32'd1);
        check("oor_no_ack", {31'd0, wb_ack_o}, 32'd0);
        @(negedge wb_clk);
        check("oor_err_one_cycle", {31'd0, wb_err_o}, 32'd0);
        check("oor_no_ack_late", {31'd0, wb_ack_o}, 32'd0);
        @(posedge wb_clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    // abort_kind: 1 = drop cyc at beat abort_at, 2 = pulse reset at beat abort_at
    task automatic burst(input int start, input int n, input bit we, input logic [1:0] bte,
                         input logic [31:0] seed, input bit seq, input int wait_at,
                         input int abort_at, input int abort_kind);
        int          waits;
        int          w;
        logic [31:0] d;
        logic [3:0]  s;
        string       nm;
        @(posedge wb_clk); #1;
        wb_cyc_i = 1'b1; wb_we_i = we; wb_bte_i = bte;
        for (int i = 0; i < n; i++) begin
            w = burst_word(start, i, bte);
            d = seq ? seed + 32'(i) : $urandom;
            s = seq ? 4'hF : 4'($urandom);
            wb_adr_i = 32'(w) << 2; wb_dat_i = d; wb_sel_i = s;
            wb_cti_i = (i == n - 1) ? CTI_EOB : CTI_INCR;
            wb_stb_i = 1'b1;
            if (i == abort_at) begin
                if (abort_kind == 1) begin
                    wb_cyc_i = 1'b0;
                    @(negedge wb_clk);
                    check("abort_cyc_no_ack", {31'd0, wb_ack_o}, 32'd0);
                end else begin
                    wb_rst = 1'b1;
                    @(negedge wb_clk);
                    check("abort_rst_no_ack", {31'd0, wb_ack_o}, 32'd0);
                    check("abort_rst_dat", wb_dat_o, 32'd0);
                end
                @(posedge wb_clk); #1;
                wb_rst = 1'b0;
                break;
            end
            if (!we) exp_q.push_back(model[w]);
            wait_ack(waits);
            nm = (i == 0) ? "burst_first_latency" : "burst_beat_latency";
            check(nm, waits, (i == 0) ? 1 : 0);
            if (we) model[w] = merge(model[w], d, s);
            @(posedge wb_clk); #1;
            if (i == wait_at && i < n - 1) begin
                wb_stb_i = 1'b0;
                repeat (2) begin
                    @(negedge wb_clk);
                    check("wait_state_no_ack", {31'd0, wb_ack_o}, 32'd0);
                    @(posedge wb_clk); #1;
                end
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = CTI_CLASSIC;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          op;
        wb_rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;

        // reset state
        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_err", {31'd0, wb_err_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        @(posedge wb_clk); #1;
        wb_rst = 1'b0;
        @(negedge wb_clk);
        check("post_rst_dat", wb_dat_o, 32'd0);
        check("post_rst_ack", {31'd0, wb_ack_o}, 32'd0);

        // give every word a known value
        burst(0, DEPTH, 1'b1, BTE_LINEAR, $urandom, 1'b1, -1, -1, 0);

        // classic write then read
        classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        classic(32'h10, 1'b0, 32'h0, 4'hF);

        // byte lanes
        classic(32'h20, 1'b1, 32'h11223344, 4'hF);
        classic(32'h20, 1'b1, 32'h0000AA00, 4'b0010);
        classic(32'h20, 1'b0, 32'h0, 4'hF);

        // linear bursts of 4 at word 0
        burst(0, 4, 1'b1, BTE_LINEAR, 32'd1, 1'b1, -1, -1, 0);
        burst(0, 4, 1'b0, BTE_LINEAR, 32'd0, 1'b0, -1, -1, 0);

        // wrap-4 from word 2; linear rollover at the top of memory
        burst(2, 4, 1'b0, BTE_WRAP4, 32'd0, 1'b0, -1, -1, 0);
        burst(1022, 4, 1'b1, BTE_LINEAR, 32'h5000, 1'b1, -1, -1, 0);
        burst(1023, 3, 1'b0, BTE_LINEAR, 32'd0, 1'b0, -1, -1, 0);
        burst(13, 8, 1'b0, BTE_WRAP16, 32'd0, 1'b0, -1, -1, 0);

        // out of range, aliased words must be untouched
        oor(32'h0000_1000, 1'b1);
        oor(32'h0000_1000, 1'b0);
        oor(32'h8000_0004, 1'b1);
        classic(32'h0, 1'b0, 32'h0, 4'hF);
        classic(32'h4, 1'b0, 32'h0, 4'hF);

        // empty lane mask write
        classic(32'h30, 1'b1, 32'hFFFF_FFFF, 4'b0000);
        classic(32'h30, 1'b0, 32'h0, 4'hF);

        // master wait states mid-burst
        burst(100, 8, 1'b0, BTE_LINEAR, 32'd0, 1'b0, 2, -1, 0);
        burst(200, 8, 1'b1, BTE_WRAP8, 32'h7000, 1'b1, 3, -1, 0);
        burst(200, 8, 1'b0, BTE_WRAP8, 32'd0, 1'b0, 5, -1, 0);

        // cyc drop and reset mid-burst, then readback
        burst(300, 6, 1'b1, BTE_LINEAR, 32'hA000, 1'b1, -1, 3, 1);
        classic(32'(303) << 2, 1'b0, 32'h0, 4'hF);
        burst(300, 6, 1'b0, BTE_LINEAR, 32'd0, 1'b0, -1, -1, 0);
        burst(400, 6, 1'b1, BTE_WRAP8, 32'hB000, 1'b1, -1, 2, 2);
        classic(32'(402) << 2, 1'b0, 32'h0, 4'hF);
        burst(400, 8, 1'b0, BTE_WRAP8, 32'd0, 1'b0, -1, -1, 0);

        // randomized mix
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 9);
            if (op < 3) begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                classic(a, 1'($urandom), $urandom, 4'($urandom));
            end else if (op == 3) begin
                a = $urandom;
                if (a[31:12] == '0) a[12] = 1'b1;
                oor(a, 1'($urandom));
            end else begin
                burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 16), 1'($urandom),
                      2'($urandom), 32'd0, 1'b0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1, -1, 0);
            end
        end

        repeat (2) @(posedge wb_clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
